// File: rtl/arm_pkg.sv
// Shared definitions for the MEM-stage data-memory path: SRAM controller state
// encoding and the board memory map / timing defaults.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } sram_state_e;

    localparam int SRAM_BASE_ADDR   = 1024;
    localparam int SRAM_WAIT_CYCLES = 5;

endpackage

// File: rtl/sram_controller.sv
// Responder for MEM-stage word accesses: each 32-bit request becomes a low then a
// high 16-bit access on an asynchronous SRAM, with ready low while in flight.
module sram_controller
    import arm_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
    parameter int BASE_ADDR   = SRAM_BASE_ADDR,
    parameter int SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            sram_dq,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_ub_n,
    output logic                   sram_lb_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    sram_state_e state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic                   is_wr_q;
    logic                   hi_q;
    logic [SRAM_ADDR_W-2:0] off_q;
    logic [31:0]            wdata_q;

    logic        req;
    logic        last;
    logic        start;
    logic        in_access;
    logic        drive;
    logic [31:0] rel;
    logic        unused_rel_bits;

    assign req       = wr_en | rd_en;
    assign rel       = address - 32'(BASE_ADDR);
    assign last      = (cnt == CNT_LAST);
    assign in_access = (state == LOW) || (state == HIGH);
    assign drive     = is_wr_q & in_access;

    // Word offset wraps modulo the SRAM size; byte-lane bits are dropped.
    assign unused_rel_bits = ^{rel[31:SRAM_ADDR_W+1], rel[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ready   = 1'b0;
        start   = 1'b0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_n = LOW;
                    cnt_n   = '0;
                    start   = 1'b1;
                end
            end
            LOW: begin
                if (last) begin
                    state_n = HIGH;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            HIGH: begin
                if (last) begin
                    state_n = DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request attributes are frozen at the start so the pipeline may change
    // its inputs freely until DONE; write wins when both enables are set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            is_wr_q   <= 1'b0;
            hi_q      <= 1'b0;
            off_q     <= '0;
            wdata_q   <= '0;
            read_data <= '0;
        end else begin
            if (start) begin
                is_wr_q <= wr_en;
                hi_q    <= 1'b0;
                off_q   <= rel[SRAM_ADDR_W:2];
                wdata_q <= write_data;
            end
            if (state == LOW && last) begin
                hi_q <= 1'b1;
                if (!is_wr_q) read_data[15:0] <= sram_dq;
            end
            if (state == HIGH && last && !is_wr_q) begin
                read_data[31:16] <= sram_dq;
            end
        end
    end

    assign sram_addr = {off_q, hi_q};
    assign sram_we_n = ~drive;
    assign sram_dq   = drive ? ((state == HIGH) ? wdata_q[31:16] : wdata_q[15:0]) : 16'bz;

    assign sram_ce_n = 1'b0;
    assign sram_oe_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule
